rf_wb_arbiter: RTL and testbench

- Shares the register file's single write port between two writeback requesters: execute-stage result (exe) and memory-load result (ld).
- Load is normally preferred. A starvation counter guarantees exe forward progress.
- The accepted write is registered one cycle before it is driven to the register file's wr/waddr/wdata.
- Sits between the pipeline writeback stages and the register file. It also exports a pending-write bitmap for hazard/stall logic.

---
 rtl/rf_wb_arbiter_pkg.sv | 30 +++
 rtl/wb_starve_ctr.sv | 43 ++++
 rtl/rf_wb_arbiter.sv | 95 +++++++++
 tb/tb_rf_wb_arbiter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// Imported by rf_wb_arbiter and wb_starve_ctr.
package rf_wb_arbiter_pkg;

    localparam int unsigned REG_COUNT    = 8;
    localparam int unsigned REG_ADDR_W   = 3;
    localparam int unsigned REG_DATA_W   = 16;
    localparam int unsigned STARVE_CNT_W = 4;

    localparam logic WB_SRC_EXE = 1'b0;
    localparam logic WB_SRC_LD  = 1'b1;

    typedef logic [REG_ADDR_W-1:0]   reg_addr_t;
    typedef logic [REG_DATA_W-1:0]   reg_data_t;
    typedef logic [STARVE_CNT_W-1:0] starve_cnt_t;

    typedef struct packed {
        logic      wr;
        reg_addr_t addr;
        reg_data_t data;
    } wb_req_t;

    function automatic logic [REG_COUNT-1:0] addr_onehot(input reg_addr_t a);
        logic [REG_COUNT-1:0] oh;
        oh    = '0;
        oh[a] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/wb_starve_ctr.sv
// Starvation counter for a two-requester shared port where ld is preferred.
// force_exe rises once exe has lost LIMIT consecutive conflicts.
module wb_starve_ctr
    import rf_wb_arbiter_pkg::*;
#(
    parameter int unsigned LIMIT = 3
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        both_req,
    input  logic        ld_win,
    input  logic        exe_req,
    output logic        force_exe,
    output starve_cnt_t count
);

    localparam starve_cnt_t LIMIT_C = STARVE_CNT_W'(LIMIT);

    starve_cnt_t cnt_q;
    starve_cnt_t cnt_d;

    // exe is granted whenever it requests and ld does not win
    always_comb begin
        cnt_d = cnt_q;
        if (!exe_req || !ld_win) begin
            cnt_d = '0;
        end else if (both_req && (cnt_q < LIMIT_C)) begin
            cnt_d = cnt_q + starve_cnt_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign force_exe = (cnt_q == LIMIT_C);
    assign count     = cnt_q;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates the register file write port between exe and ld writeback.
// Optional RF_WB_R0_DROP_EN: granted writes to r0 are acked but never issued.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  exe_req,
    input  logic [REG_ADDR_W-1:0] exe_addr,
    input  logic [REG_DATA_W-1:0] exe_data,
    output logic                  exe_gnt,
    input  logic                  ld_req,
    input  logic [REG_ADDR_W-1:0] ld_addr,
    input  logic [REG_DATA_W-1:0] ld_data,
    output logic                  ld_gnt,
    output logic                  rf_wr,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [REG_DATA_W-1:0] rf_wdata,
    output logic [REG_COUNT-1:0]  pend
);

    logic        both_req;
    logic        force_exe;
    starve_cnt_t starve_cnt;
    logic        win_src;
    logic        any_gnt;
    logic        drop;
    wb_req_t     wb_q;
    wb_req_t     wb_d;

    assign both_req = exe_req & ld_req;

    wb_starve_ctr #(
        .LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk      (clk),
        .rstn     (rstn),
        .both_req (both_req),
        .ld_win   (ld_gnt),
        .exe_req  (exe_req),
        .force_exe(force_exe),
        .count    (starve_cnt)
    );

    assign ld_gnt  = rstn & ld_req & ~(exe_req & force_exe);
    assign exe_gnt = rstn & exe_req & ~(ld_req & ~force_exe);
    assign any_gnt = exe_gnt | ld_gnt;
    assign win_src = exe_gnt ? WB_SRC_EXE : WB_SRC_LD;

    always_comb begin
        wb_d    = wb_q;
        wb_d.wr = 1'b0;
        drop    = 1'b0;
        unique case (1'b1)
            any_gnt && (win_src == WB_SRC_EXE): begin
                wb_d.addr = exe_addr;
                wb_d.data = exe_data;
            end
            any_gnt && (win_src == WB_SRC_LD): begin
                wb_d.addr = ld_addr;
                wb_d.data = ld_data;
            end
            default: ;
        endcase
`ifdef RF_WB_R0_DROP_EN
        drop = any_gnt && (wb_d.addr == '0);
`endif
        // a dropped r0 write leaves the output address/data untouched
        if (drop) begin
            wb_d = wb_q;
            wb_d.wr = 1'b0;
        end else begin
            wb_d.wr = any_gnt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wb_q <= '0;
        end else begin
            wb_q <= wb_d;
        end
    end

    assign rf_wr    = wb_q.wr;
    assign rf_waddr = wb_q.addr;
    assign rf_wdata = wb_q.data;
    assign pend     = wb_q.wr ? addr_onehot(wb_q.addr) : '0;

    logic unused_cnt;
    assign unused_cnt = ^starve_cnt;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter.
// Inputs change on negedge; grants checked #1 later, outputs at next negedge.
module tb_rf_wb_arbiter;

    logic        clk;
    logic        rstn;
    logic        exe_req;
    logic [2:0]  exe_addr;
    logic [15:0] exe_data;
    logic        exe_gnt;
    logic        ld_req;
    logic [2:0]  ld_addr;
    logic [15:0] ld_data;
    logic        ld_gnt;
    logic        rf_wr;
    logic [2:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic [7:0]  pend;

    int n_chk;
    int n_pass;

    logic [15:0] rf_model [8];

    rf_wb_arbiter #(
        .STARVE_LIMIT(3)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .exe_req (exe_req),
        .exe_addr(exe_addr),
        .exe_data(exe_data),
        .exe_gnt (exe_gnt),
        .ld_req  (ld_req),
        .ld_addr (ld_addr),
        .ld_data (ld_data),
        .ld_gnt  (ld_gnt),
        .rf_wr   (rf_wr),
        .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata),
        .pend    (pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural register file fed by the write port
    always @(posedge clk) begin
        if (rf_wr) rf_model[rf_waddr] <= rf_wdata;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic er, input logic [2:0] ea,
                         input logic [15:0] ed, input logic lr,
                         input logic [2:0] la, input logic [15:0] ld);
        exe_req  = er;
        exe_addr = ea;
        exe_data = ed;
        ld_req   = lr;
        ld_addr  = la;
        ld_data  = ld;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        logic exp_exe;
        n_chk  = 0;
        n_pass = 0;
        for (int r = 0; r < 8; r++) rf_model[r] = 16'h0;
        rstn = 1'b0;
        drive(1'b1, 3'd1, 16'h0101, 1'b1, 3'd3, 16'h0303);

        // reset held with both requests high
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_exe_gnt", {31'b0, exe_gnt}, 32'd0);
            check("rst_ld_gnt", {31'b0, ld_gnt}, 32'd0);
            check("rst_rf_wr", {31'b0, rf_wr}, 32'd0);
            check("rst_pend", {24'b0, pend}, 32'd0);
        end

        rstn = 1'b1;
        #1;
        check("post_rst_ld_gnt", {31'b0, ld_gnt}, 32'd1);
        check("post_rst_exe_gnt", {31'b0, exe_gnt}, 32'd0);
        tick();
        check("post_rst_wr", {31'b0, rf_wr}, 32'd1);
        check("post_rst_waddr", {29'b0, rf_waddr}, 32'd3);
        check("post_rst_wdata", {16'b0, rf_wdata}, 32'h0303);

        // idle cycle: no grant, address/data hold, counter clears
        drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
        #1;
        check("idle_gnt", {30'b0, exe_gnt, ld_gnt}, 32'd0);
        tick();
        check("idle_wr", {31'b0, rf_wr}, 32'd0);
        check("idle_waddr_hold", {29'b0, rf_waddr}, 32'd3);
        check("idle_wdata_hold", {16'b0, rf_wdata}, 32'h0303);

        // single exe requester
        drive(1'b1, 3'd5, 16'hBEEF, 1'b0, 3'd0, 16'h0);
        #1;
        check("single_exe_gnt", {31'b0, exe_gnt}, 32'd1);
        check("single_ld_gnt", {31'b0, ld_gnt}, 32'd0);
        tick();
        drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
        check("single_wr", {31'b0, rf_wr}, 32'd1);
        check("single_waddr", {29'b0, rf_waddr}, 32'd5);
        check("single_wdata", {16'b0, rf_wdata}, 32'hBEEF);
        check("single_pend", {24'b0, pend}, 32'h20);
        tick();

        // starvation: exe wins every 4th conflict cycle
        for (int i = 0; i < 8; i++) begin
            exp_exe = (i == 3) || (i == 7);
            drive(1'b1, 3'd7, 16'h7777, 1'b1, 3'd6, 16'(i));
            #1;
            check($sformatf("starve_exe_gnt%0d", i), {31'b0, exe_gnt},
                  {31'b0, exp_exe});
            check($sformatf("starve_ld_gnt%0d", i), {31'b0, ld_gnt},
                  {31'b0, ~exp_exe});
            tick();
            check($sformatf("starve_waddr%0d", i), {29'b0, rf_waddr},
                  exp_exe ? 32'd7 : 32'd6);
            check($sformatf("starve_wdata%0d", i), {16'b0, rf_wdata},
                  exp_exe ? 32'h7777 : i);
        end
        drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
        tick();

        // same-address conflict: ld first, exe second, exe data lands last
        drive(1'b1, 3'd2, 16'h1111, 1'b1, 3'd2, 16'h2222);
        #1;
        check("same_ld_gnt", {31'b0, ld_gnt}, 32'd1);
        tick();
        ld_req = 1'b0;
        check("same_first_wdata", {16'b0, rf_wdata}, 32'h2222);
        #1;
        check("same_exe_gnt", {31'b0, exe_gnt}, 32'd1);
        tick();
        drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
        check("same_second_wr", {31'b0, rf_wr}, 32'd1);
        check("same_second_wdata", {16'b0, rf_wdata}, 32'h1111);
        tick();
        check("same_r2_final", {16'b0, rf_model[2]}, 32'h1111);

        // reset with a write sitting in the output stage
        drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd4, 16'h00AA);
        #1;
        check("midrst_ld_gnt", {31'b0, ld_gnt}, 32'd1);
        tick();
        drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
        rstn = 1'b0;
        tick();
        check("midrst_wr", {31'b0, rf_wr}, 32'd0);
        check("midrst_pend", {24'b0, pend}, 32'd0);
        check("midrst_waddr", {29'b0, rf_waddr}, 32'd0);
        ld_req = 1'b1;
        #1;
        check("midrst_gnt_forced", {31'b0, ld_gnt}, 32'd0);
        ld_req = 1'b0;
        tick();
        rstn = 1'b1;

        // write to r0
        drive(1'b1, 3'd0, 16'hFFFF, 1'b0, 3'd0, 16'h0);
        #1;
        check("r0_exe_gnt", {31'b0, exe_gnt}, 32'd1);
        tick();
        drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
`ifdef RF_WB_R0_DROP_EN
        check("r0_wr", {31'b0, rf_wr}, 32'd0);
        check("r0_pend", {24'b0, pend}, 32'd0);
`else
        check("r0_wr", {31'b0, rf_wr}, 32'd1);
        check("r0_waddr", {29'b0, rf_waddr}, 32'd0);
        check("r0_pend", {24'b0, pend}, 32'd1);
`endif
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
